mirror_period_meter: RTL
========================

# mirror_period_meter

Measures the resonant mirror's oscillation period from the raw zero-crossing comparator output and delivers a clean zero-crossing, a period word in system-clock ticks, and a lock flag. Sits directly upstream of the laser synchronizer: `zc_o` drives its `zc_i` and `freq_o` drives its `freq_i`, replacing the fixed nominal period. The block synchronizes and deglitches the comparator, averages periods over fixed windows, detects lock and detects loss of signal.

## Interface
- `SYSCLOCK_P`, 500000000: system clock in Hz.
- `MIRROR_FREQ_P`, 10800: nominal mirror frequency in Hz. `PERIOD_NOM_P = SYSCLOCK_P/MIRROR_FREQ_P` (46296) is a localparam.
- `FILTER_CYCLES_P`, 8: number of stable cycles required before `zc_o` changes level.
- `AVG_LOG2_P`, 2: log2 of the number of periods per averaging window.
- `LOCK_TOL_P`, 256: maximum allowed |difference| in ticks between consecutive periods.
- `LOCK_COUNT_P`, 4: number of consecutive in-tolerance periods needed for lock.
- `TIMEOUT_P`, 2*PERIOD_NOM_P: number of ticks without a rising edge before signal loss is declared.
- `clk_i` in 1: system clock.
- `nrst_i` in 1: asynchronous, active-low reset.
- `zc_raw_i` in 1: comparator output. It is asynchronous to `clk_i`.
- `zc_o` out 1: synchronized, deglitched zero-crossing level.
- `zc_rise_o` out 1: one-cycle pulse on each 0→1 transition of `zc_o`.
- `freq_o` out 24: averaged period in ticks.
- `freq_valid_o` out 1: one-cycle pulse when `freq_o` updates.
- `locked_o` out 1: period is stable.
- `timeout_o` out 1: no rising edge seen within `TIMEOUT_P`.

## Operation
- **Synchronizer:** 2-flop synchronizer on `zc_raw_i`.
- **Deglitch filter:**
  - The filter counter clears whenever the synchronized value equals `zc_o`. Otherwise it increments.
  - When the counter reaches `FILTER_CYCLES_P`, `zc_o` takes the synchronized value and the counter clears.
  - `zc_rise_o` asserts in the same cycle that `zc_o` goes 0→1.
- **Period counter:**
  - 24-bit counter, cleared to 0 on `zc_rise_o`, otherwise incrementing.
  - It saturates at `TIMEOUT_P`.
  - Captured period = counter + 1, sampled on `zc_rise_o`.
- **FSM:**
  - `S_WAIT_EDGE` (reset state): on the first rise, clear the counter, accumulator and match count, then go to `S_ACQUIRE`. No period is captured on this rise.
  - `S_ACQUIRE`: every rise captures a period. When the match count reaches `LOCK_COUNT_P`, go to `S_LOCKED`.
  - `S_LOCKED`: a captured period outside tolerance clears the match count and returns to `S_ACQUIRE`.
  - From `S_ACQUIRE` or `S_LOCKED`: when the counter reaches `TIMEOUT_P`, go to `S_WAIT_EDGE`.
- **Lock tracking:**
  - Each capture after the first in a run is compared with the previous capture.
  - If |diff| ≤ `LOCK_TOL_P`, the match count increments, saturating at `LOCK_COUNT_P`. Otherwise it clears to 0.
  - `locked_o` = 1 exactly in `S_LOCKED`.
- **Averaging:**
  - The accumulator is `24+AVG_LOG2_P` bits wide and sums captured periods.
  - After 2^`AVG_LOG2_P` captures: `freq_o` ← accumulator >> `AVG_LOG2_P` (truncated), `freq_valid_o` pulses, and the accumulator restarts.
  - Windows do not overlap. Averaging runs in both `S_ACQUIRE` and `S_LOCKED`.
- **Timeout:**
  - `timeout_o` sets, `locked_o` clears, and the accumulator and match count clear.
  - `freq_o` holds its last value.
  - `timeout_o` clears on the next `zc_rise_o`.
- **Simultaneous events:**
  - A rise in the same cycle the counter hits `TIMEOUT_P` counts as a rise; no timeout occurs. The captured value is `TIMEOUT_P`+1, which fails tolerance.
  - `zc_rise_o` in the cycle of the timeout transition is not possible: the counter clears on any rise.
- **Reset values:**
  - `zc_o` = 0, `zc_rise_o` = 0, `freq_o` = `PERIOD_NOM_P[23:0]`, `freq_valid_o` = 0, `locked_o` = 0, `timeout_o` = 0.
  - All counters = 0. FSM = `S_WAIT_EDGE`.
  - Reset asserted mid-window discards the partial window immediately (asynchronous).

## Timing
- `zc_raw_i` edge to `zc_o`/`zc_rise_o`: 2 + `FILTER_CYCLES_P` cycles (10 at defaults), provided the input is stable.
- Glitches shorter than `FILTER_CYCLES_P` synchronized cycles never reach `zc_o`.
- `zc_rise_o` to `freq_o`/`freq_valid_o`/`locked_o`/`timeout_o` update: 1 cycle, all registered.
- `freq_o` is stable between `freq_valid_o` pulses. Downstream may sample it at any time.
- Earliest `locked_o` after reset: 1 cycle after rise number `LOCK_COUNT_P`+2.

## Structure
- **Shared package/header:** FSM state encodings (`S_WAIT_EDGE`, `S_ACQUIRE`, `S_LOCKED`) and `FREQ_W` = 24. The laser synchronizer already uses a 24-bit `freq_i`, so `FREQ_W` is the common width.
- **Sub-module `zc_deglitch`:** 2-flop synchronizer plus filter counter; outputs `zc_o` and `zc_rise_o`. The top level holds the period counter, FSM, lock logic and averager.

## Test plan
1. **Clean lock:** `zc_raw_i` square wave toggling every 23149 cycles (period 46298).
   - `freq_valid_o` first pulses after the 5th rise, then every 4 rises.
   - `freq_o` = 46298.
   - `locked_o` = 1 one cycle after the 6th rise.
2. **Glitch rejection:** 5-cycle pulse on `zc_raw_i` mid-phase → `zc_o` and `zc_rise_o` unchanged; period and lock unaffected.
3. **Loss of signal:** stop toggling once locked.
   - 92592 cycles after the last rise: `timeout_o` = 1, `locked_o` = 0, `freq_o` holds 46298.
   - On the next rise, `timeout_o` = 0.
4. **Period step:** step period to 47298 while locked.
   - `locked_o` drops 1 cycle after the first long capture.
   - Relock after 4 further matching periods.
   - `freq_o` reaches 47298 after the next full window.
5. **Jitter:** alternate periods of 46198 and 46398 (±100 ticks) → `locked_o` stays 1; `freq_o` = 46298.
6. **Reset mid-window:** assert `nrst_i` after 2 captures.
   - All outputs return to reset values immediately; `freq_o` = 46296.
   - After release, the first rise produces no capture.

Source files
------------

// File: rtl/mirror_period_meter_pkg.sv
// rtl/mirror_period_meter_pkg.sv - shared width, FSM states and helpers for the mirror period meter
package mirror_period_meter_pkg;

  localparam int FREQ_W = 24;

  typedef enum logic [1:0] {
    S_WAIT_EDGE = 2'd0,
    S_ACQUIRE   = 2'd1,
    S_LOCKED    = 2'd2
  } state_t;

  function automatic logic [FREQ_W-1:0] abs_diff(input logic [FREQ_W-1:0] a,
                                                 input logic [FREQ_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/mirror_period_meter_zc_deglitch.sv
// rtl/mirror_period_meter_zc_deglitch.sv - comparator synchronizer and stability filter
module zc_deglitch #(
  parameter int FILTER_CYCLES_P = 8
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic zc_raw_i,
  output logic zc_o,
  output logic zc_rise_o
);

  localparam int CNT_W = $clog2(FILTER_CYCLES_P + 1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FILTER_CYCLES_P - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_zc;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_commit;

  assign w_differs = (r_sync != r_zc);
  // The last counted cycle commits the new level, so the count never sits at FILTER_CYCLES_P.
  assign w_commit  = w_differs && (r_cnt == LAST_C);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_zc   <= 1'b0;
      r_rise <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= zc_raw_i;
      r_sync <= r_meta;
      r_rise <= w_commit && r_sync;
      if (!w_differs || w_commit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_commit) begin
        r_zc <= r_sync;
      end
    end
  end

  assign zc_o      = r_zc;
  assign zc_rise_o = r_rise;

endmodule

// File: rtl/mirror_period_meter.sv
// rtl/mirror_period_meter.sv - mirror period measurement, window averaging, lock and loss-of-signal detection
module mirror_period_meter
  import mirror_period_meter_pkg::*;
#(
  parameter int SYSCLOCK_P      = 500000000,
  parameter int MIRROR_FREQ_P   = 10800,
  parameter int FILTER_CYCLES_P = 8,
  parameter int AVG_LOG2_P      = 2,
  parameter int LOCK_TOL_P      = 256,
  parameter int LOCK_COUNT_P    = 4,
  parameter int TIMEOUT_P       = 2 * (SYSCLOCK_P / MIRROR_FREQ_P)
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              zc_raw_i,
  output logic              zc_o,
  output logic              zc_rise_o,
  output logic [FREQ_W-1:0] freq_o,
  output logic              freq_valid_o,
  output logic              locked_o,
  output logic              timeout_o
);

  localparam int PERIOD_NOM_P = SYSCLOCK_P / MIRROR_FREQ_P;
  localparam int ACC_W        = FREQ_W + AVG_LOG2_P;
  localparam int WIN_W        = AVG_LOG2_P + 1;
  localparam int MATCH_W      = $clog2(LOCK_COUNT_P + 1);

  localparam logic [FREQ_W-1:0]  TIMEOUT_C    = FREQ_W'(TIMEOUT_P);
  localparam logic [FREQ_W-1:0]  LOCK_TOL_C   = FREQ_W'(LOCK_TOL_P);
  localparam logic [FREQ_W-1:0]  NOM_C        = FREQ_W'(PERIOD_NOM_P);
  localparam logic [MATCH_W-1:0] LOCK_COUNT_C = MATCH_W'(LOCK_COUNT_P);
  localparam logic [WIN_W-1:0]   WIN_LAST_C   = WIN_W'((1 << AVG_LOG2_P) - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [FREQ_W-1:0]  r_per_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [WIN_W-1:0]   r_win_cnt;
  logic [MATCH_W-1:0] r_match;
  logic [FREQ_W-1:0]  r_prev;
  logic               r_have_prev;
  logic [FREQ_W-1:0]  r_freq;
  logic               r_freq_valid;
  logic               r_timeout;

  logic               w_rise;
  logic               w_active;
  logic               w_cap_en;
  logic               w_at_limit;
  logic               w_timeout;
  logic [FREQ_W-1:0]  w_capture;
  logic               w_in_tol;
  logic [MATCH_W-1:0] w_match_next;
  logic [ACC_W-1:0]   w_acc_sum;
  logic               w_win_done;

  zc_deglitch #(
    .FILTER_CYCLES_P(FILTER_CYCLES_P)
  ) u_zc_deglitch (
    .clk_i    (clk_i),
    .nrst_i   (nrst_i),
    .zc_raw_i (zc_raw_i),
    .zc_o     (zc_o),
    .zc_rise_o(w_rise)
  );

  assign w_active   = (r_state != S_WAIT_EDGE);
  assign w_cap_en   = w_rise && w_active;
  assign w_at_limit = (r_per_cnt == TIMEOUT_C);
  // A rise landing on the saturation cycle wins over the timeout.
  assign w_timeout  = w_active && w_at_limit && !w_rise;
  assign w_capture  = r_per_cnt + 1'b1;
  assign w_in_tol   = (abs_diff(w_capture, r_prev) <= LOCK_TOL_C);
  assign w_acc_sum  = r_acc + ACC_W'(w_capture);
  assign w_win_done = w_cap_en && (r_win_cnt == WIN_LAST_C);

  always_comb begin
    w_match_next = r_match;
    if (w_cap_en && r_have_prev) begin
      if (!w_in_tol) begin
        w_match_next = '0;
      end else if (r_match != LOCK_COUNT_C) begin
        w_match_next = r_match + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_WAIT_EDGE: begin
        if (w_rise) w_state_next = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (w_timeout) begin
          w_state_next = S_WAIT_EDGE;
        end else if (w_match_next == LOCK_COUNT_C) begin
          w_state_next = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (w_timeout) begin
          w_state_next = S_WAIT_EDGE;
        end else if (w_cap_en && r_have_prev && !w_in_tol) begin
          w_state_next = S_ACQUIRE;
        end
      end
      default: w_state_next = S_WAIT_EDGE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state      <= S_WAIT_EDGE;
      r_per_cnt    <= '0;
      r_acc        <= '0;
      r_win_cnt    <= '0;
      r_match      <= '0;
      r_prev       <= '0;
      r_have_prev  <= 1'b0;
      r_freq       <= NOM_C;
      r_freq_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_freq_valid <= 1'b0;

      if (w_rise) begin
        r_per_cnt <= '0;
      end else if (!w_at_limit) begin
        r_per_cnt <= r_per_cnt + 1'b1;
      end

      if (w_rise) begin
        r_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_timeout <= 1'b1;
      end

      // A new run (first rise or signal loss) starts with an empty window and no reference period.
      if (w_timeout || (w_rise && !w_active)) begin
        r_acc       <= '0;
        r_win_cnt   <= '0;
        r_match     <= '0;
        r_have_prev <= 1'b0;
      end else if (w_cap_en) begin
        r_match     <= w_match_next;
        r_prev      <= w_capture;
        r_have_prev <= 1'b1;
        if (w_win_done) begin
          r_freq       <= FREQ_W'(w_acc_sum >> AVG_LOG2_P);
          r_freq_valid <= 1'b1;
          r_acc        <= '0;
          r_win_cnt    <= '0;
        end else begin
          r_acc     <= w_acc_sum;
          r_win_cnt <= r_win_cnt + 1'b1;
        end
      end
    end
  end

  assign zc_rise_o    = w_rise;
  assign freq_o       = r_freq;
  assign freq_valid_o = r_freq_valid;
  assign locked_o     = (r_state == S_LOCKED);
  assign timeout_o    = r_timeout;

endmodule
